serial_pattern_tx: RTL and testbench

SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

---
 rtl/serial_pattern_pkg.sv | 17 +
 rtl/serial_pattern_tx_piso_shift.sv | 46 ++++
 rtl/serial_pattern_tx.sv | 97 +++++++++
 tb/tb_serial_pattern_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pattern_pkg.sv
// Shared types and line-level constants for the serial pattern transmitter.
// The state enum is the single source of truth for the frame sequencer encoding.
package serial_pattern_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/serial_pattern_tx_piso_shift.sv
// Parallel-in serial-out shift register with a bit counter.
// Load takes priority over shift and clears the counter.
module piso_shift #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    count_q, count_d;

  // NOTE: every signal assigned in always_comb gets a default first so no path infers a latch.
  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    if (load) begin
      shift_d = din;
      count_d = '0;
    end else if (shift_en) begin
      shift_d = {1'b0, shift_q[WIDTH-1:1]};
      count_d = count_q + CW'(1);
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      count_q <= '0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

  assign sout  = shift_q[0];
  assign count = count_q;

endmodule

// File: rtl/serial_pattern_tx.sv
// Framed serial transmitter: start bit, LSB-first payload, optional even parity, stop bit.
// Outputs depend only on registered state, so data/valid never reach y, busy or done combinationally.
module serial_pattern_tx
  import serial_pattern_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int PARITY = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  output logic             y,
  output logic             busy,
  output logic             done
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e        state_q, state_d;
  logic          par_q, par_d;
  logic          load;
  logic          shift_en;
  logic          sout;
  logic [CW-1:0] count;

  assign load = valid && ready;

  piso_shift #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_piso (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .shift_en (shift_en),
    .din      (data),
    .sout     (sout),
    .count    (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      par_q   <= par_d;
    end
  end

  // Parity is latched with the payload so later data changes cannot disturb it.
  always_comb begin
    state_d = state_q;
    par_d   = load ? ^data : par_q;
    case (state_q)
      ST_IDLE:   if (load) state_d = ST_START;
      ST_START:  state_d = ST_DATA;
      ST_DATA:   if (count == LAST_BIT) state_d = (PARITY == 1) ? ST_PARITY : ST_STOP;
      ST_PARITY: state_d = ST_STOP;
      ST_STOP:   state_d = load ? ST_START : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready    = 1'b0;
    y        = IDLE_LEVEL;
    busy     = 1'b1;
    done     = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
      end
      ST_START:  y = START_BIT;
      ST_DATA: begin
        y        = sout;
        shift_en = 1'b1;
      end
      ST_PARITY: y = par_q;
      ST_STOP: begin
        y     = STOP_BIT;
        ready = 1'b1;
        done  = 1'b1;
      end
      default: begin
        ready = 1'b1;
        busy  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench: a parity and a no-parity instance checked cycle by cycle
// against frames built from the line protocol, plus a passive decoder of the serial line.
module tb_serial_pattern_tx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] data_p = '0, data_n = '0;
  logic         valid_p = 1'b0, valid_n = 1'b0;
  logic         ready_p, y_p, busy_p, done_p;
  logic         ready_n, y_n, busy_n, done_n;

  int checks = 0;
  int passed = 0;

  serial_pattern_tx #(.WIDTH(W), .PARITY(1)) dut_p (
    .clk(clk), .reset_n(reset_n), .data(data_p), .valid(valid_p),
    .ready(ready_p), .y(y_p), .busy(busy_p), .done(done_p)
  );

  serial_pattern_tx #(.WIDTH(W), .PARITY(0)) dut_n (
    .clk(clk), .reset_n(reset_n), .data(data_n), .valid(valid_n),
    .ready(ready_n), .y(y_n), .busy(busy_n), .done(done_n)
  );

  always #5 clk = ~clk;

  // Serial-line recognizer on the parity instance: idle until a 1, then W data bits, parity, stop.
  int           mon_pos = -1;
  int           mon_frames = 0;
  logic [W-1:0] mon_data = '0;
  logic         mon_par = 1'b0;
  logic         mon_stop = 1'b0;

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_pos <= -1;
    end else if (mon_pos < 0) begin
      if (y_p) mon_pos <= 0;
    end else if (mon_pos < W) begin
      mon_data[mon_pos] <= y_p;
      mon_pos <= mon_pos + 1;
    end else if (mon_pos == W) begin
      mon_par <= y_p;
      mon_pos <= W + 1;
    end else begin
      mon_stop   <= (y_p == 1'b0);
      mon_frames <= mon_frames + 1;
      mon_pos    <= -1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line bits of one frame, in transmission order.
  task automatic build_frame(input logic [W-1:0] d, input bit par, output bit fr[$]);
    fr = {};
    fr.push_back(1'b1);
    for (int i = 0; i < W; i++) fr.push_back(d[i]);
    if (par) fr.push_back(^d);
    fr.push_back(1'b0);
  endtask

  task automatic drive(input bit sel, input logic v, input logic [W-1:0] d);
    if (sel) begin
      valid_n = v;
      data_n  = d;
    end else begin
      valid_p = v;
      data_p  = d;
    end
  endtask

  function automatic logic [3:0] obs(input bit sel);
    return sel ? {y_n, busy_n, done_n, ready_n} : {y_p, busy_p, done_p, ready_p};
  endfunction

  // Sends ds[] back to back on one instance (sel=1: no-parity) with junk on valid/data mid-frame.
  task automatic run_chain(input bit sel, input logic [W-1:0] ds[$], input string tag,
                           output logic [63:0] ycap);
    bit         fr[$];
    logic [3:0] got, exp;
    ycap = '0;
    drive(sel, 1'b1, ds[0]);
    tick();
    for (int f = 0; f < ds.size(); f++) begin
      build_frame(ds[f], !sel, fr);
      for (int k = 1; k <= fr.size(); k++) begin
        got = obs(sel);
        exp = {fr[k-1], 1'b1, k == fr.size(), k == fr.size()};
        checks++;
        if (got !== exp)
          $display("FAIL %s frame %0d cycle %0d: got %b expected %b (y,busy,done,ready)",
                   tag, f, k, got, exp);
        else passed++;
        ycap = {ycap[62:0], got[3]};
        if (k < fr.size()) drive(sel, 1'($urandom_range(0, 1)), W'($urandom));
        else if (f + 1 < ds.size()) drive(sel, 1'b1, ds[f+1]);
        else drive(sel, 1'b0, W'($urandom));
        tick();
      end
    end
    got = obs(sel);
    checks++;
    if (got !== 4'b0001) $display("FAIL %s idle after frames: got %b expected 0001", tag, got);
    else passed++;
  endtask

  task automatic test_reset();
    logic [63:0] ycap;
    logic [W-1:0] q[$];
    #1;
    checks++;
    if (obs(0) !== 4'b0001) $display("FAIL reset_p: got %b expected 0001", obs(0));
    else passed++;
    checks++;
    if (obs(1) !== 4'b0001) $display("FAIL reset_n: got %b expected 0001", obs(1));
    else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    q = {W'($urandom)};
    run_chain(0, q, "first_after_reset", ycap);
  endtask

  task automatic test_spec_vector();
    logic [63:0] ycap;
    logic [W-1:0] q[$];
    int f0;
    f0 = mon_frames;
    q = {8'hA5};
    run_chain(0, q, "a5_parity", ycap);
    checks++;
    if (ycap[10:0] !== 11'b11010010100)
      $display("FAIL a5_line: got %b expected 11010010100", ycap[10:0]);
    else passed++;
    checks++;
    if (mon_frames != f0 + 1 || mon_data !== 8'hA5 || mon_par !== 1'b0 || mon_stop !== 1'b1)
      $display("FAIL recognizer: frames %0d data %h par %b stop %b expected frames %0d data a5 par 0 stop 1",
               mon_frames, mon_data, mon_par, mon_stop, f0 + 1);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] ycap;
    logic [W-1:0] q[$];
    q = {8'h01, 8'hFF};
    run_chain(1, q, "b2b_01_ff", ycap);
    checks++;
    if (ycap[19:0] !== 20'b1100000000_1111111110)
      $display("FAIL b2b_line: got %b expected 11000000001111111110", ycap[19:0]);
    else passed++;
    q = {W'($urandom), W'($urandom), W'($urandom)};
    run_chain(0, q, "b2b_parity_rand", ycap);
  endtask

  task automatic test_random();
    logic [63:0] ycap;
    logic [W-1:0] q[$];
    for (int r = 0; r < 16; r++) begin
      q = {};
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) q.push_back(W'($urandom));
      run_chain(r[0], q, "random", ycap);
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] ycap;
    logic [W-1:0] d;
    logic [W-1:0] q[$];
    bit           fr[$];
    int           f0;
    d = W'($urandom);
    build_frame(d, 1'b1, fr);
    f0 = mon_frames;
    drive(0, 1'b1, d);
    tick();
    drive(0, 1'b0, d);
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (obs(0) !== {fr[k-1], 3'b100})
        $display("FAIL pre_reset cycle %0d: got %b expected %b", k, obs(0), {fr[k-1], 3'b100});
      else passed++;
      if (k < 5) tick();
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs(0) !== 4'b0001) $display("FAIL async_reset: got %b expected 0001", obs(0));
    else passed++;
    tick();
    checks++;
    if (obs(0) !== 4'b0001) $display("FAIL held_reset: got %b expected 0001", obs(0));
    else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (obs(0) !== 4'b0001) $display("FAIL post_reset_idle %0d: got %b expected 0001", k, obs(0));
      else passed++;
    end
    q = {W'($urandom)};
    run_chain(0, q, "fresh_after_abort", ycap);
    checks++;
    if (mon_frames != f0 + 1 || mon_data !== q[0])
      $display("FAIL abort_recognizer: frames %0d data %h expected frames %0d data %h",
               mon_frames, mon_data, f0 + 1, q[0]);
    else passed++;
  endtask

  task automatic test_idle();
    drive(0, 1'b0, W'($urandom));
    drive(1, 1'b0, W'($urandom));
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (obs(0) !== 4'b0001) $display("FAIL idle_p cycle %0d: got %b expected 0001", k, obs(0));
      else passed++;
      checks++;
      if (obs(1) !== 4'b0001) $display("FAIL idle_n cycle %0d: got %b expected 0001", k, obs(1));
      else passed++;
      data_p = W'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_spec_vector();
    test_back_to_back();
    test_idle();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
